// File: rtl/bus_lane_packer_pkg.sv
// Shared types and helpers for the bus lane packer: FSM states, lane
// placement and the width of the lane counter.
package bus_pack_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic int lane_index(input int k, input int ratio, input bit msb_first);
    if (msb_first) begin
      return ratio - 1 - k;
    end else begin
      return k;
    end
  endfunction

  // Counter must represent 0..ratio inclusive (ratio = full word waiting).
  function automatic int count_width(input int ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/bus_lane_packer_insert.sv
// Combinational lane writer: drops one narrow beat into the selected lane
// of a wide word and sets the matching mask bit.
module bus_lane_insert
  import bus_pack_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int RATIO = 4,
  parameter int LW    = $clog2(RATIO)
) (
  input  logic [IN_W*RATIO-1:0] word_i,
  input  logic [RATIO-1:0]      mask_i,
  input  logic [LW-1:0]         lane_i,
  input  logic [IN_W-1:0]       beat_i,
  output logic [IN_W*RATIO-1:0] word_o,
  output logic [RATIO-1:0]      mask_o
);

  // Overwrite only the addressed lane; all other lanes pass through.
  always_comb begin
    word_o = word_i;
    mask_o = mask_i;
    for (int l = 0; l < RATIO; l++) begin
      if (lane_i == LW'(l)) begin
        word_o[l*IN_W +: IN_W] = beat_i;
        mask_o[l]              = 1'b1;
      end else begin
        word_o[l*IN_W +: IN_W] = word_i[l*IN_W +: IN_W];
        mask_o[l]              = mask_i[l];
      end
    end
  end

endmodule

// File: rtl/bus_lane_packer.sv
// Packs RATIO narrow beats into one wide word with valid/ready on both sides,
// flush of partial words with a lane mask, and a single output holding register.
module bus_lane_packer
  import bus_pack_pkg::*;
#(
  parameter int IN_W      = 4,
  parameter int RATIO     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [IN_W-1:0]              in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         flush,
  output logic [IN_W*RATIO-1:0]        out_data,
  output logic [RATIO-1:0]             out_mask,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(RATIO+1)-1:0]   count
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int CW    = count_width(RATIO);
  localparam int LW    = $clog2(RATIO);

  if (RATIO < 2 || IN_W < 1) begin : g_bad_params
    $error("bus_lane_packer: RATIO must be >= 2 and IN_W >= 1");
  end

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [RATIO-1:0]   acc_mask_q, acc_mask_d;
  logic [CW-1:0]      count_q, count_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic [RATIO-1:0]   out_mask_q, out_mask_d;
  logic               out_valid_q, out_valid_d;

  logic               in_fire_s, out_fire_s, slot_free_s, close_s;
  logic [LW-1:0]      lane_s;
  logic [OUT_W-1:0]   ins_word_s, new_word_s, load_word_s;
  logic [RATIO-1:0]   ins_mask_s, new_mask_s, load_mask_s;
  logic               load_s;

  assign in_fire_s   = in_valid & in_ready;
  assign out_fire_s  = out_valid_q & out_ready;
  assign slot_free_s = ~out_valid_q | out_ready;
  assign lane_s      = LW'(lane_index(int'(count_q), RATIO, MSB_FIRST != 0));

  // The word closes on the last lane, or on a flush that has something to send.
  assign close_s = (in_fire_s && (count_q == CW'(RATIO - 1))) ||
                   (flush && ((count_q != {CW{1'b0}}) || in_fire_s));

  bus_lane_insert #(
    .IN_W  (IN_W),
    .RATIO (RATIO),
    .LW    (LW)
  ) u_insert (
    .word_i (acc_q),
    .mask_i (acc_mask_q),
    .lane_i (lane_s),
    .beat_i (in_data),
    .word_o (ins_word_s),
    .mask_o (ins_mask_s)
  );

  assign new_word_s = in_fire_s ? ins_word_s : acc_q;
  assign new_mask_s = in_fire_s ? ins_mask_s : acc_mask_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (close_s && !slot_free_s) begin
          state_d = HOLD;
        end else begin
          state_d = FILL;
        end
      end
      HOLD: begin
        if (slot_free_s) begin
          state_d = FILL;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // FSM-driven output: beats accepted only while filling.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      FILL:    in_ready = 1'b1;
      HOLD:    in_ready = 1'b0;
      default: in_ready = 1'b0;
    endcase
  end

  // Accumulator and output-register next values.
  always_comb begin
    acc_d       = acc_q;
    acc_mask_d  = acc_mask_q;
    count_d     = count_q;
    load_s      = 1'b0;
    load_word_s = acc_q;
    load_mask_s = acc_mask_q;
    case (state_q)
      FILL: begin
        if (close_s) begin
          if (slot_free_s) begin
            load_s      = 1'b1;
            load_word_s = new_word_s;
            load_mask_s = new_mask_s;
            acc_d       = {OUT_W{1'b0}};
            acc_mask_d  = {RATIO{1'b0}};
            count_d     = {CW{1'b0}};
          end else begin
            acc_d      = new_word_s;
            acc_mask_d = new_mask_s;
            count_d    = count_q + CW'(in_fire_s);
          end
        end else if (in_fire_s) begin
          acc_d      = new_word_s;
          acc_mask_d = new_mask_s;
          count_d    = count_q + CW'(1);
        end else begin
          count_d = count_q;
        end
      end
      HOLD: begin
        if (slot_free_s) begin
          load_s     = 1'b1;
          acc_d      = {OUT_W{1'b0}};
          acc_mask_d = {RATIO{1'b0}};
          count_d    = {CW{1'b0}};
        end else begin
          count_d = count_q;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase

    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    out_valid_d = out_valid_q;
    if (load_s) begin
      out_data_d  = load_word_s;
      out_mask_d  = load_mask_s;
      out_valid_d = 1'b1;
    end else if (out_fire_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Datapath registers; a reset discards any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= {OUT_W{1'b0}};
      acc_mask_q  <= {RATIO{1'b0}};
      count_q     <= {CW{1'b0}};
      out_data_q  <= {OUT_W{1'b0}};
      out_mask_q  <= {RATIO{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      acc_mask_q  <= acc_mask_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_mask  = out_mask_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;

endmodule

// File: tb/tb_bus_lane_packer.sv
// Directed table-driven bench for bus_lane_packer: an LSB-first and an
// MSB-first instance share stimulus; each row lists the state after the edge.
module tb_bus_lane_packer;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_data;
  logic        in_valid;
  logic        flush;
  logic        out_ready;

  logic        in_ready,  in_ready_m;
  logic [15:0] out_data,  out_data_m;
  logic [3:0]  out_mask,  out_mask_m;
  logic        out_valid, out_valid_m;
  logic [2:0]  count,     count_m;

  int vectors;
  int miscompares;

  bus_lane_packer #(.IN_W(4), .RATIO(4), .MSB_FIRST(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_data(out_data), .out_mask(out_mask),
    .out_valid(out_valid), .out_ready(out_ready), .count(count)
  );

  bus_lane_packer #(.IN_W(4), .RATIO(4), .MSB_FIRST(1)) u_dut_m (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_m), .flush(flush), .out_data(out_data_m), .out_mask(out_mask_m),
    .out_valid(out_valid_m), .out_ready(out_ready), .count(count_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          iv;
    logic [3:0]  d;
    bit          fl;
    bit          ordy;
    bit          ir;
    bit          ov;
    logic [15:0] od;
    logic [3:0]  om;
    int          cnt;
    logic [15:0] odm;
    logic [3:0]  omm;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rst, input bit iv, input logic [3:0] d, input bit fl,
                     input bit ordy, input bit ir, input bit ov, input logic [15:0] od,
                     input logic [3:0] om, input int cnt, input logic [15:0] odm,
                     input logic [3:0] omm);
    vec_t v;
    v.rst = rst; v.iv = iv; v.d = d; v.fl = fl; v.ordy = ordy;
    v.ir = ir; v.ov = ov; v.od = od; v.om = om; v.cnt = cnt;
    v.odm = odm; v.omm = omm;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s row %0d: got 0x%0h, expected 0x%0h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit iv, input logic [3:0] d,
                       input bit fl, input bit ordy);
    rst_n     = rst;
    in_valid  = iv;
    in_data   = d;
    flush     = fl;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 4'h0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // rst iv  d     fl ordy | ir ov  od        om     cnt  odm       omm
    add(1'b0,1'b0,4'h0,1'b0,1'b1, 1'b1,1'b0,16'h0000,4'h0, 0, 16'h0000,4'h0);
    // back-to-back streaming, one word every four beats
    add(1'b1,1'b1,4'h1,1'b0,1'b1, 1'b1,1'b0,16'h0000,4'h0, 1, 16'h0000,4'h0);
    add(1'b1,1'b1,4'h2,1'b0,1'b1, 1'b1,1'b0,16'h0000,4'h0, 2, 16'h0000,4'h0);
    add(1'b1,1'b1,4'h3,1'b0,1'b1, 1'b1,1'b0,16'h0000,4'h0, 3, 16'h0000,4'h0);
    add(1'b1,1'b1,4'h4,1'b0,1'b1, 1'b1,1'b1,16'h4321,4'hF, 0, 16'h1234,4'hF);
    add(1'b1,1'b1,4'h5,1'b0,1'b1, 1'b1,1'b0,16'h4321,4'hF, 1, 16'h1234,4'hF);
    add(1'b1,1'b1,4'h6,1'b0,1'b1, 1'b1,1'b0,16'h4321,4'hF, 2, 16'h1234,4'hF);
    add(1'b1,1'b1,4'h7,1'b0,1'b1, 1'b1,1'b0,16'h4321,4'hF, 3, 16'h1234,4'hF);
    add(1'b1,1'b1,4'h8,1'b0,1'b1, 1'b1,1'b1,16'h8765,4'hF, 0, 16'h5678,4'hF);
    add(1'b1,1'b0,4'h0,1'b0,1'b1, 1'b1,1'b0,16'h8765,4'hF, 0, 16'h5678,4'hF);
    // reset in the middle of a word
    add(1'b1,1'b1,4'h9,1'b0,1'b1, 1'b1,1'b0,16'h8765,4'hF, 1, 16'h5678,4'hF);
    add(1'b1,1'b1,4'h9,1'b0,1'b1, 1'b1,1'b0,16'h8765,4'hF, 2, 16'h5678,4'hF);
    add(1'b0,1'b1,4'h9,1'b0,1'b1, 1'b1,1'b0,16'h0000,4'h0, 0, 16'h0000,4'h0);
    add(1'b1,1'b1,4'h1,1'b0,1'b1, 1'b1,1'b0,16'h0000,4'h0, 1, 16'h0000,4'h0);
    add(1'b1,1'b1,4'h2,1'b0,1'b1, 1'b1,1'b0,16'h0000,4'h0, 2, 16'h0000,4'h0);
    add(1'b1,1'b1,4'h3,1'b0,1'b1, 1'b1,1'b0,16'h0000,4'h0, 3, 16'h0000,4'h0);
    add(1'b1,1'b1,4'h4,1'b0,1'b1, 1'b1,1'b1,16'h4321,4'hF, 0, 16'h1234,4'hF);
    add(1'b1,1'b0,4'h0,1'b0,1'b1, 1'b1,1'b0,16'h4321,4'hF, 0, 16'h1234,4'hF);
    // backpressure: second word parks in HOLD with count saturated
    add(1'b1,1'b1,4'h1,1'b0,1'b0, 1'b1,1'b0,16'h4321,4'hF, 1, 16'h1234,4'hF);
    add(1'b1,1'b1,4'h2,1'b0,1'b0, 1'b1,1'b0,16'h4321,4'hF, 2, 16'h1234,4'hF);
    add(1'b1,1'b1,4'h3,1'b0,1'b0, 1'b1,1'b0,16'h4321,4'hF, 3, 16'h1234,4'hF);
    add(1'b1,1'b1,4'h4,1'b0,1'b0, 1'b1,1'b1,16'h4321,4'hF, 0, 16'h1234,4'hF);
    add(1'b1,1'b1,4'h5,1'b0,1'b0, 1'b1,1'b1,16'h4321,4'hF, 1, 16'h1234,4'hF);
    add(1'b1,1'b1,4'h6,1'b0,1'b0, 1'b1,1'b1,16'h4321,4'hF, 2, 16'h1234,4'hF);
    add(1'b1,1'b1,4'h7,1'b0,1'b0, 1'b1,1'b1,16'h4321,4'hF, 3, 16'h1234,4'hF);
    add(1'b1,1'b1,4'h8,1'b0,1'b0, 1'b0,1'b1,16'h4321,4'hF, 4, 16'h1234,4'hF);
    add(1'b1,1'b1,4'h9,1'b0,1'b0, 1'b0,1'b1,16'h4321,4'hF, 4, 16'h1234,4'hF);
    add(1'b1,1'b0,4'h0,1'b0,1'b1, 1'b1,1'b1,16'h8765,4'hF, 0, 16'h5678,4'hF);
    add(1'b1,1'b0,4'h0,1'b0,1'b1, 1'b1,1'b0,16'h8765,4'hF, 0, 16'h5678,4'hF);
    // flush of a two-beat partial word, then an empty flush
    add(1'b1,1'b1,4'hA,1'b0,1'b1, 1'b1,1'b0,16'h8765,4'hF, 1, 16'h5678,4'hF);
    add(1'b1,1'b1,4'hB,1'b0,1'b1, 1'b1,1'b0,16'h8765,4'hF, 2, 16'h5678,4'hF);
    add(1'b1,1'b0,4'h0,1'b1,1'b1, 1'b1,1'b1,16'h00BA,4'h3, 0, 16'hAB00,4'hC);
    add(1'b1,1'b0,4'h0,1'b1,1'b1, 1'b1,1'b0,16'h00BA,4'h3, 0, 16'hAB00,4'hC);
    add(1'b1,1'b0,4'h0,1'b0,1'b1, 1'b1,1'b0,16'h00BA,4'h3, 0, 16'hAB00,4'hC);
    // flush together with the third beat
    add(1'b1,1'b1,4'hA,1'b0,1'b1, 1'b1,1'b0,16'h00BA,4'h3, 1, 16'hAB00,4'hC);
    add(1'b1,1'b1,4'hB,1'b0,1'b1, 1'b1,1'b0,16'h00BA,4'h3, 2, 16'hAB00,4'hC);
    add(1'b1,1'b1,4'hC,1'b1,1'b1, 1'b1,1'b1,16'h0CBA,4'h7, 0, 16'hABC0,4'hE);
    add(1'b1,1'b0,4'h0,1'b0,1'b1, 1'b1,1'b0,16'h0CBA,4'h7, 0, 16'hABC0,4'hE);
    // flush together with the completing beat: one word, nothing after
    add(1'b1,1'b1,4'h1,1'b0,1'b1, 1'b1,1'b0,16'h0CBA,4'h7, 1, 16'hABC0,4'hE);
    add(1'b1,1'b1,4'h2,1'b0,1'b1, 1'b1,1'b0,16'h0CBA,4'h7, 2, 16'hABC0,4'hE);
    add(1'b1,1'b1,4'h3,1'b0,1'b1, 1'b1,1'b0,16'h0CBA,4'h7, 3, 16'hABC0,4'hE);
    add(1'b1,1'b1,4'h4,1'b1,1'b1, 1'b1,1'b1,16'h4321,4'hF, 0, 16'h1234,4'hF);
    add(1'b1,1'b0,4'h0,1'b0,1'b1, 1'b1,1'b0,16'h4321,4'hF, 0, 16'h1234,4'hF);
    add(1'b1,1'b0,4'h0,1'b0,1'b1, 1'b1,1'b0,16'h4321,4'hF, 0, 16'h1234,4'hF);
    // flush while the output register is stalled
    add(1'b1,1'b1,4'h1,1'b0,1'b0, 1'b1,1'b0,16'h4321,4'hF, 1, 16'h1234,4'hF);
    add(1'b1,1'b1,4'h2,1'b0,1'b0, 1'b1,1'b0,16'h4321,4'hF, 2, 16'h1234,4'hF);
    add(1'b1,1'b1,4'h3,1'b0,1'b0, 1'b1,1'b0,16'h4321,4'hF, 3, 16'h1234,4'hF);
    add(1'b1,1'b1,4'h4,1'b0,1'b0, 1'b1,1'b1,16'h4321,4'hF, 0, 16'h1234,4'hF);
    add(1'b1,1'b1,4'hA,1'b0,1'b0, 1'b1,1'b1,16'h4321,4'hF, 1, 16'h1234,4'hF);
    add(1'b1,1'b0,4'h0,1'b1,1'b0, 1'b0,1'b1,16'h4321,4'hF, 1, 16'h1234,4'hF);
    add(1'b1,1'b0,4'h0,1'b1,1'b0, 1'b0,1'b1,16'h4321,4'hF, 1, 16'h1234,4'hF);
    add(1'b1,1'b0,4'h0,1'b0,1'b1, 1'b1,1'b1,16'h000A,4'h1, 0, 16'hA000,4'h8);
    add(1'b1,1'b0,4'h0,1'b0,1'b1, 1'b1,1'b0,16'h000A,4'h1, 0, 16'hA000,4'h8);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].iv, tbl[i].d, tbl[i].fl, tbl[i].ordy);
      vectors++;
      chk("in_ready",    i, 32'(in_ready),    32'(tbl[i].ir));
      chk("out_valid",   i, 32'(out_valid),   32'(tbl[i].ov));
      chk("out_data",    i, 32'(out_data),    32'(tbl[i].od));
      chk("out_mask",    i, 32'(out_mask),    32'(tbl[i].om));
      chk("count",       i, 32'(count),       32'(tbl[i].cnt));
      chk("in_ready_m",  i, 32'(in_ready_m),  32'(tbl[i].ir));
      chk("out_valid_m", i, 32'(out_valid_m), 32'(tbl[i].ov));
      chk("out_data_m",  i, 32'(out_data_m),  32'(tbl[i].odm));
      chk("out_mask_m",  i, 32'(out_mask_m),  32'(tbl[i].omm));
      chk("count_m",     i, 32'(count_m),     32'(tbl[i].cnt));
    end

    // Long stall: the word must stay frozen until the consumer takes it.
    for (int b = 1; b <= 4; b++) begin
      drive(1'b1, 1'b1, 4'(b), 1'b0, 1'b0);
    end
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      vectors++;
      chk("stall_valid", 100 + c, 32'(out_valid), 32'd1);
      chk("stall_data",  100 + c, 32'(out_data),  32'h4321);
      chk("stall_mask",  100 + c, 32'(out_mask),  32'hF);
    end
    begin
      bit drained;
      drained = 1'b0;
      for (int c = 0; c < 4 && !drained; c++) begin
        drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
        if (!out_valid) drained = 1'b1;
      end
      vectors++;
      chk("drain_timeout", 200, 32'(drained), 32'd1);
      chk("drain_data",    200, 32'(out_data), 32'h4321);
      chk("drain_count",   200, 32'(count),    32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_lane_packer.md
Name: bus_lane_packer

Overview:
Parametrised, registered successor to the fixed-width bus breakout/concatenation logic. It accepts a stream of narrow IN_W-bit beats and packs RATIO consecutive beats into one wide output word. Both sides use valid/ready handshakes, with backpressure and an explicit flush that emits a partial word with a lane mask. It sits between narrow sensor/peripheral buses and the wide internal datapath.

Parameters:
IN_W, 4, width of one input beat (lane); must be >= 1
RATIO, 4, lanes per output word; must be >= 2; OUT_W = IN_W*RATIO
MSB_FIRST, 0, 0: beat k goes to lane k (LSB lane first); 1: beat k goes to lane RATIO-1-k

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset; asynchronous, active-low
in_data  input  IN_W  narrow input beat
in_valid  input  1  in_data valid
in_ready  output  1  packer can accept a beat
flush  input  1  single-cycle request to emit the current partial word
out_data  output  IN_W*RATIO  packed word
out_mask  output  RATIO  1 per lane holding valid data
out_valid  output  1  out_data/out_mask valid
out_ready  input  1  downstream accepts word
count  output  $clog2(RATIO+1)  lanes currently held in the accumulator

Behaviour:
- Reset (rst_n low, async): state=FILL, count=0, accumulator=0, out_valid=0, out_data=0, out_mask=0. Any partial word is discarded. in_ready follows state (1), but beats are ignored while rst_n is low.
- Storage: accumulator (acc, acc_mask, count) plus one output holding register. in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; slot_free = !out_valid | out_ready.
- Lane placement: beat index k = count at acceptance; lane = MSB_FIRST ? RATIO-1-k : k; data written to lane bits [lane*IN_W +: IN_W]; mask bit lane set.
- States: FILL (in_ready=1), HOLD (in_ready=0; acc complete or flush pending, waiting for output slot).
- FILL, in_fire with count==RATIO-1, or flush with count+in_fire>0:
  - if slot_free: load output register with acc|new lane and its mask the same edge; out_valid=1 next cycle; acc cleared, count=0; stay FILL. This gives full throughput: 1 word per RATIO cycles, no bubble.
  - else: write lane into acc; state=HOLD.
- FILL, other in_fire: write lane, count+1.
- flush with count==0 and no in_fire: ignored; no empty word is ever emitted.
- flush in the same cycle as a beat: the beat is included first, then the word is emitted. A flush coinciding with the completing beat yields exactly one full word.
- HOLD: on slot_free, move acc to the output register, clear acc, count=0, return to FILL. flush during HOLD is ignored (the word is already closing).
- Output register: out_data/out_mask stable while out_valid & !out_ready. On out_fire with no new load, out_valid=0 next cycle and data/mask are retained. Unused lanes of a partial word are zero.
- Latency: completing beat or flush -> out_valid next cycle when slot free.
- count saturates at RATIO (in HOLD after a full word); it never wraps.
- Elaboration error if RATIO<2 or IN_W<1.

Decomposition:
- Package bus_pack_pkg: state enum (FILL, HOLD), function lane_index(k, ratio, msb_first), count-width constant helper.
- One sub-module: bus_lane_insert. Combinational; inputs word, mask, lane, beat; outputs updated word and mask. Used by both the accumulator path and the direct-to-output path.

Test Plan:
- Reset mid-word: 2 beats in, rst_n low 1 cycle -> count=0, out_valid=0; next 4 beats 1,2,3,4 yield only 0x4321.
- IN_W=4, RATIO=4, MSB_FIRST=0: beats 0x1,0x2,0x3,0x4 back-to-back, out_ready=1 -> out_data=0x4321, out_mask=0xF, out_valid one cycle after 4th beat, in_ready never drops; repeat continuously for 1 word per 4 cycles.
- MSB_FIRST=1, same stimulus -> out_data=0x1234, out_mask=0xF.
- Backpressure: out_ready=0, send 0x1..0x8 -> 0x4321 held stable, count reaches 4, in_ready=0. Raise out_ready -> 0x4321 then 0x8765, no loss or duplication.
- Flush after beats 0xA,0xB -> out_data=0x00BA, out_mask=0x3. Flush with count=0 -> no output. Flush with 3rd beat 0xC after 0xA,0xB -> 0x0CBA, mask 0x7.
- Flush coinciding with 4th beat -> single word, mask 0xF, no trailing empty word. Flush while out_valid & !out_ready -> state HOLD, word emitted after out_ready.
